// File: rtl/control_unit_mc.sv
// Multi-cycle instruction sequencer: fetch, decode, execute (DP/branch/load-store)
// with optional memory-wait timeout, illegal-opcode trap and a retired counter.
module control_unit_mc #(
  parameter int K_WIDTH     = 32,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          IR,
  input  logic [3:0]           status,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic                 link_we,
  output logic                 alu_b_sel_k,
  output logic                 status_load,
  output logic [2:0]           k_sel,
  output logic [K_WIDTH-1:0]   k,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC_DP = 3'd2,
    S_EXEC_BR = 3'd3,
    S_MEM     = 3'd4,
    S_TRAP    = 3'd7
  } state_e;

  localparam int          WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [31:0] TIMEOUT_L = MEM_TIMEOUT;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic [31:0]            wait_ext;
  logic                   timeout_hit;
  logic                   retire, taken;
  logic                   cond_base, cond_ok;
  logic [K_WIDTH-1:0]     k_val;

  logic is_dp_imm, is_br, is_dp_reg, is_ls, is_movz;
  logic is_b, is_bl, is_cbz, is_cbnz, is_bcond;
  logic flag_v, flag_c, flag_n, flag_z;

  assign {flag_v, flag_c, flag_n, flag_z} = status;

  assign is_dp_imm = (IR[28:26] == 3'b100);
  assign is_br     = (IR[28:26] == 3'b101);
  assign is_dp_reg = IR[27] & ~IR[26] & IR[25];
  assign is_ls     = IR[27] & ~IR[25];
  assign is_movz   = (IR[28:23] == 6'b100101);
  assign is_b      = (IR[31:26] == 6'b000101);
  assign is_bl     = (IR[31:26] == 6'b100101);
  assign is_cbz    = (IR[31:24] == 8'hB4);
  assign is_cbnz   = (IR[31:24] == 8'hB5);
  assign is_bcond  = (IR[31:24] == 8'h54);

  // Condition codes come in pairs: even code tests the base term, odd code its inverse.
  always_comb begin
    case (IR[3:1])
      3'd0:    cond_base = flag_z;
      3'd1:    cond_base = flag_c;
      3'd2:    cond_base = flag_n;
      3'd3:    cond_base = flag_v;
      3'd4:    cond_base = flag_c & ~flag_z;
      3'd5:    cond_base = (flag_n == flag_v);
      3'd6:    cond_base = ~flag_z & (flag_n == flag_v);
      default: cond_base = 1'b1;
    endcase
    cond_ok = (IR[3:1] == 3'b111) ? 1'b1 : (cond_base ^ IR[0]);
  end

  assign wait_ext    = {{(32-WAIT_W){1'b0}}, wait_q};
  assign timeout_hit = (MEM_TIMEOUT > 0) && ((wait_ext + 32'd1) == TIMEOUT_L);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    retire      = 1'b0;
    taken       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    link_we     = 1'b0;
    alu_b_sel_k = 1'b0;
    status_load = 1'b0;
    k_sel       = 3'd0;
    trap        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else if (MEM_TIMEOUT > 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_dp_imm)      state_d = S_EXEC_DP;
        else if (is_br)     state_d = S_EXEC_BR;
        else if (is_dp_reg) state_d = S_EXEC_DP;
        else if (is_ls)     state_d = S_MEM;
        else                state_d = S_TRAP;
      end
      S_EXEC_DP: begin
        reg_we      = 1'b1;
        status_load = IR[29];
        if (is_dp_imm) begin
          alu_b_sel_k = 1'b1;
          k_sel       = is_movz ? 3'd5 : 3'd1;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC_BR: begin
        // Unrecognised branch encodings retire nothing and trap.
        if (is_b || is_bl) begin
          k_sel   = 3'd3;
          taken   = 1'b1;
          link_we = is_bl;
        end else if (is_cbz || is_cbnz || is_bcond) begin
          k_sel = 3'd4;
          if (is_cbz)       taken = alu_zero;
          else if (is_cbnz) taken = ~alu_zero;
          else              taken = cond_ok;
        end
        pc_load = taken;
        if (is_b || is_bl || is_cbz || is_cbnz || is_bcond) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req     = 1'b1;
        addr_sel    = 1'b1;
        alu_b_sel_k = 1'b1;
        k_sel       = 3'd2;
        mem_we      = ~IR[22];
        if (mem_ready) begin
          reg_we  = IR[22];
          wb_sel  = IR[22];
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else if (MEM_TIMEOUT > 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_d = '0;
    retired_d = retire ? (retired_q + CNT_WIDTH'(1)) : retired_q;

    // Reset masks every strobe so an access in flight is abandoned cleanly.
    if (!reset_n) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      link_we     = 1'b0;
      alu_b_sel_k = 1'b0;
      status_load = 1'b0;
      k_sel       = 3'd0;
      trap        = 1'b0;
    end
  end

  always_comb begin
    case (k_sel)
      3'd0:    k_val = {{(K_WIDTH-6){1'b0}}, IR[15:10]};
      3'd1:    k_val = {{(K_WIDTH-12){1'b0}}, IR[21:10]};
      3'd2:    k_val = {{(K_WIDTH-9){IR[20]}}, IR[20:12]};
      3'd3:    k_val = {{(K_WIDTH-26){IR[25]}}, IR[25:0]};
      3'd4:    k_val = {{(K_WIDTH-19){IR[23]}}, IR[23:5]};
      3'd5:    k_val = {{(K_WIDTH-16){1'b0}}, IR[20:5]};
      default: k_val = '0;
    endcase
    k = reset_n ? k_val : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
